fft_peak_detect: RTL and testbench

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_cplx_mag.sv | 28 ++
 rtl/fft_peak_detect.sv | 160 ++++++++++++++++
 tb/tb_fft_peak_detect.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT peak detector.
// Contents: default transform size and output width, magnitude/bin types, detector states.
package fft_pkg;

  localparam int unsigned DEF_LGN    = 12;
  localparam int unsigned DEF_N      = 1 << DEF_LGN;
  localparam int unsigned DEF_OWIDTH = 19;

  // |re|+|im| of two DEF_OWIDTH-bit signed components needs one extra bit
  typedef logic [DEF_OWIDTH:0]  mag_t;
  typedef logic [DEF_LGN-1:0]   bin_t;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_t;

endpackage

// File: rtl/fft_cplx_mag.sv
// Complex magnitude approximation |re|+|im|, combinational, full precision.
// Ports:
//   i_cplx  {re, im}, each OWIDTH-bit two's complement
//   o_mag   unsigned |re|+|im|, OWIDTH+1 bits
module fft_cplx_mag
  import fft_pkg::*;
#(
  parameter int unsigned OWIDTH = DEF_OWIDTH
) (
  input  logic [2*OWIDTH-1:0] i_cplx,
  output logic [OWIDTH:0]     o_mag
);

  logic [OWIDTH-1:0] w_re;
  logic [OWIDTH-1:0] w_im;
  logic [OWIDTH-1:0] w_re_abs;
  logic [OWIDTH-1:0] w_im_abs;

  assign w_re = i_cplx[2*OWIDTH-1:OWIDTH];
  assign w_im = i_cplx[OWIDTH-1:0];

  // Read as unsigned, the negation of the most negative value is exactly 2^(OWIDTH-1)
  assign w_re_abs = w_re[OWIDTH-1] ? -w_re : w_re;
  assign w_im_abs = w_im[OWIDTH-1] ? -w_im : w_im;

  assign o_mag = {1'b0, w_re_abs} + {1'b0, w_im_abs};

endmodule

// File: rtl/fft_peak_detect.sv
// Finds the bin with the largest |re|+|im| in each FFT frame delivered as
// even/odd bin pairs, and reports it with a one-cycle strobe.
// Ports:
//   i_clk, i_reset (async, active-high), i_clk_enable (qualifies all updates)
//   i_sync          marks the pair carrying bins 0 and 1
//   i_left/i_right  {re, im} of the even/odd bin
//   o_valid         result strobe; o_peak_bin/o_peak_mag hold between strobes
//   o_resync        strobe when i_sync aborts a partial frame
// Build option: define FFT_PEAK_DC_SKIP_EN to exclude bin 0 from the search.
// Internal widths come from fft_pkg types, so LGN/OWIDTH must match its defaults.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int unsigned LGN    = DEF_LGN,
  parameter int unsigned OWIDTH = DEF_OWIDTH
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_clk_enable,
  input  logic                i_sync,
  input  logic [2*OWIDTH-1:0] i_left,
  input  logic [2*OWIDTH-1:0] i_right,
  output logic                o_valid,
  output logic [LGN-1:0]      o_peak_bin,
  output logic [OWIDTH:0]     o_peak_mag,
  output logic                o_resync
);

`ifdef FFT_PEAK_DC_SKIP_EN
  localparam logic DcSkip = 1'b1;
`else
  localparam logic DcSkip = 1'b0;
`endif

  localparam logic [LGN-2:0] LastPair = '1;
  localparam logic [LGN-2:0] PairOne  = {{(LGN-2){1'b0}}, 1'b1};

  state_t         r_state;
  state_t         w_state_next;
  logic [LGN-2:0] r_count;

  logic           w_accept;
  logic [LGN-2:0] w_pair;
  logic           w_last;
  logic           w_resync;
  mag_t           w_mag_l;
  mag_t           w_mag_r;

  // Stage 1
  logic           r_s1_valid;
  logic           r_s1_last;
  logic [LGN-2:0] r_s1_pair;
  mag_t           r_s1_mag_l;
  mag_t           r_s1_mag_r;

  // Stage 2
  logic           r_s2_done;
  bin_t           r_max_bin;
  mag_t           r_max_mag;

  logic           w_take_right;
  mag_t           w_cand_mag;
  bin_t           w_cand_bin;
  logic           w_update;

  fft_cplx_mag #(.OWIDTH(OWIDTH)) u_mag_left (
    .i_cplx (i_left),
    .o_mag  (w_mag_l)
  );

  fft_cplx_mag #(.OWIDTH(OWIDTH)) u_mag_right (
    .i_cplx (i_right),
    .o_mag  (w_mag_r)
  );

  // A sync always restarts at pair 0, whatever state we were in
  assign w_accept = i_sync | (r_state == StRun);
  assign w_pair   = i_sync ? '0 : r_count;
  assign w_last   = (w_pair == LastPair);
  assign w_resync = i_sync & (r_state == StRun) & (r_count != '0);

  always_comb begin
    w_state_next = r_state;
    if (i_clk_enable && w_accept) begin
      w_state_next = w_last ? StIdle : StRun;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_pair  <= '0;
      r_s1_mag_l <= '0;
      r_s1_mag_r <= '0;
    end else if (i_clk_enable) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        // Wraps to 0 after the last pair, ready for the next frame
        r_count    <= w_pair + PairOne;
        r_s1_last  <= w_last;
        r_s1_pair  <= w_pair;
        r_s1_mag_l <= w_mag_l;
        r_s1_mag_r <= w_mag_r;
      end
    end
  end

  // Left wins a tie, so the lower bin is kept
  assign w_take_right = (DcSkip && (r_s1_pair == '0)) ? 1'b1 : (r_s1_mag_r > r_s1_mag_l);
  assign w_cand_mag   = w_take_right ? r_s1_mag_r : r_s1_mag_l;
  assign w_cand_bin   = {r_s1_pair, w_take_right};
  // Pair 0 seeds the running max, which also discards any aborted partial frame
  assign w_update     = (r_s1_pair == '0) || (w_cand_mag > r_max_mag);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s2_done <= 1'b0;
      r_max_bin <= '0;
      r_max_mag <= '0;
    end else if (i_clk_enable) begin
      r_s2_done <= r_s1_valid & r_s1_last;
      if (r_s1_valid && w_update) begin
        r_max_bin <= w_cand_bin;
        r_max_mag <= w_cand_mag;
      end
    end
  end

  // Strobes clear on every edge; results only move on enabled edges
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid    <= 1'b0;
      o_resync   <= 1'b0;
      o_peak_bin <= '0;
      o_peak_mag <= '0;
    end else begin
      o_valid  <= 1'b0;
      o_resync <= 1'b0;
      if (i_clk_enable) begin
        o_resync <= w_resync;
        if (r_s2_done) begin
          o_valid    <= 1'b1;
          o_peak_bin <= r_max_bin;
          o_peak_mag <= r_max_mag;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: expected peaks are pushed when a full
// frame has been driven and compared when o_valid fires.
module tb_fft_peak_detect;

  localparam int LGN = 12;
  localparam int OW  = 19;
  localparam int NB  = 4096;
  localparam int NP  = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sync;
  logic [2*OW-1:0] left;
  logic [2*OW-1:0] right;
  logic          o_valid;
  logic [LGN-1:0] o_peak_bin;
  logic [OW:0]   o_peak_mag;
  logic          o_resync;

  always #5 clk = ~clk;

  fft_peak_detect #(.LGN(LGN), .OWIDTH(OW)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_clk_enable (en),
    .i_sync       (sync),
    .i_left       (left),
    .i_right      (right),
    .o_valid      (o_valid),
    .o_peak_bin   (o_peak_bin),
    .o_peak_mag   (o_peak_mag),
    .o_resync     (o_resync)
  );

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int resync_cnt = 0;
  bit gaps = 1'b0;
  int fr_re [NB];
  int fr_im [NB];
  int exp_bin_q [$];
  int exp_mag_q [$];

  int mon_bin;
  int mon_mag;
  logic [LGN-1:0] mon_bin_v;
  logic [OW:0]    mon_mag_v;

  // Scoreboard consumer
  always @(negedge clk) begin
    if (o_resync === 1'b1) resync_cnt++;
    if (o_valid === 1'b1) begin
      valid_cnt++;
      checks++;
      if (exp_bin_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got bin=%0d mag=%0d, required no strobe",
                 o_peak_bin, o_peak_mag);
      end else begin
        mon_bin = exp_bin_q.pop_front();
        mon_mag = exp_mag_q.pop_front();
        mon_bin_v = mon_bin[LGN-1:0];
        mon_mag_v = mon_mag[OW:0];
        if (o_peak_bin !== mon_bin_v || o_peak_mag !== mon_mag_v) begin
          errors++;
          $display("FAIL peak_result: got bin=%0d mag=%0d, required bin=%0d mag=%0d",
                   o_peak_bin, o_peak_mag, mon_bin_v, mon_mag_v);
        end
      end
    end
  end

  function automatic logic [2*OW-1:0] pack(input int re, input int im);
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    a = re[OW-1:0];
    b = im[OW-1:0];
    return {a, b};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic clear_frame();
    for (int b = 0; b < NB; b++) begin
      fr_re[b] = 0;
      fr_im[b] = 0;
    end
  endtask

  task automatic set_bin(input int b, input int re, input int im);
    fr_re[b] = re;
    fr_im[b] = im;
  endtask

  // Reference: linear scan, strictly-greater keeps the lowest bin on ties
  task automatic model_push();
    int best_b;
    int best_m;
    int first_b;
    int m;
`ifdef FFT_PEAK_DC_SKIP_EN
    first_b = 1;
`else
    first_b = 0;
`endif
    best_b = first_b;
    best_m = iabs(fr_re[first_b]) + iabs(fr_im[first_b]);
    for (int b = first_b + 1; b < NB; b++) begin
      m = iabs(fr_re[b]) + iabs(fr_im[b]);
      if (m > best_m) begin
        best_m = m;
        best_b = b;
      end
    end
    exp_bin_q.push_back(best_b);
    exp_mag_q.push_back(best_m);
  endtask

  // Holds the pair until an enabled edge has sampled it
  task automatic drive_pair(input bit s, input int p);
    bit en_v;
    do begin
      en_v  = gaps ? ($urandom_range(0, 9) >= 3) : 1'b1;
      en    = en_v;
      sync  = s;
      left  = pack(fr_re[2*p], fr_im[2*p]);
      right = pack(fr_re[2*p+1], fr_im[2*p+1]);
      @(posedge clk);
      #1;
    end while (!en_v);
  endtask

  task automatic drive_frame(input int from, input int to, input bit sync_first,
                             input bit push);
    for (int p = from; p <= to; p++) drive_pair(sync_first && (p == from), p);
    sync = 1'b0;
    if (push) model_push();
  endtask

  task automatic idle(input int n);
    en    = 1'b1;
    sync  = 1'b0;
    left  = '0;
    right = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int limit);
    en   = 1'b1;
    sync = 1'b0;
    for (int i = 0; i < limit && exp_bin_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (exp_bin_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", exp_bin_q.size());
      exp_bin_q.delete();
      exp_mag_q.delete();
    end
  endtask

  task automatic check_held(input string name, input int bin, input int mag);
    checks++;
    if (o_peak_bin !== bin[LGN-1:0] || o_peak_mag !== mag[OW:0]) begin
      errors++;
      $display("FAIL %s: got bin=%0d mag=%0d, required bin=%0d mag=%0d",
               name, o_peak_bin, o_peak_mag, bin, mag);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (o_valid !== 1'b0 || o_resync !== 1'b0 || o_peak_bin !== '0 || o_peak_mag !== '0) begin
      errors++;
      $display("FAIL %s: got valid=%b resync=%b bin=%0d mag=%0d, required all 0",
               name, o_valid, o_resync, o_peak_bin, o_peak_mag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sync = 1'b0; left = '0; right = '0;
    #1;
    check_zero_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    check_zero_outputs("reset_idle");
  endtask

  task automatic test_single_peak();
    clear_frame();
    set_bin(2000, 30000, -4000);
    drive_frame(0, NP - 1, 1'b1, 1'b1);
    en = 1'b1; sync = 1'b0; left = '0; right = '0;
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge1: got valid=%b, required 0", o_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b1 || o_peak_bin !== 12'd2000 || o_peak_mag !== 20'd34000) begin
      errors++;
      $display("FAIL latency_edge2: got valid=%b bin=%0d mag=%0d, required 1 2000 34000",
               o_valid, o_peak_bin, o_peak_mag);
    end
    wait_drain(20);
    idle(2);
    check_held("hold_after_strobe", 2000, 34000);
  endtask

  task automatic test_ties();
    clear_frame();
    set_bin(10, 500, 0);
    set_bin(11, 500, 0);
    drive_frame(0, NP - 1, 1'b1, 1'b1);
    wait_drain(20);
    check_held("tie_in_pair", 10, 500);
    clear_frame();
    set_bin(7, 0, -800);
    set_bin(100, 0, -800);
    drive_frame(0, NP - 1, 1'b1, 1'b1);
    wait_drain(20);
    check_held("tie_across_pairs", 7, 800);
  endtask

  task automatic test_max_negative();
    clear_frame();
    set_bin(4095, -262144, -262144);
    drive_frame(0, NP - 1, 1'b1, 1'b1);
    wait_drain(20);
    check_held("most_negative", 4095, 524288);
  endtask

  task automatic test_resync();
    int r0;
    int v0;
    clear_frame();
    set_bin(100, 200000, 0);
    drive_frame(0, 499, 1'b1, 1'b0);
    r0 = resync_cnt;
    v0 = valid_cnt;
    clear_frame();
    set_bin(3000, 1000, 1000);
    drive_pair(1'b1, 0);
    checks++;
    if (o_resync !== 1'b1) begin
      errors++;
      $display("FAIL resync_strobe: got %b, required 1", o_resync);
    end
    drive_frame(1, NP - 1, 1'b0, 1'b1);
    wait_drain(20);
    idle(5);
    checks++;
    if (resync_cnt - r0 != 1 || valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL resync_counts: got resync=%0d valid=%0d, required 1 1",
               resync_cnt - r0, valid_cnt - v0);
    end
    check_held("resync_result", 3000, 2000);
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    clear_frame();
    set_bin(1234, 5000, -7);
    drive_frame(0, NP - 1, 1'b1, 1'b1);
    clear_frame();
    set_bin(77, -9000, 0);
    drive_frame(0, NP - 1, 1'b1, 1'b1);
    wait_drain(20);
    idle(3);
    checks++;
    if (valid_cnt - v0 != 2) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d, required 2", valid_cnt - v0);
    end
  endtask

  task automatic test_enable_gaps();
    gaps = 1'b1;
    clear_frame();
    set_bin(2000, 30000, -4000);
    drive_frame(0, NP - 1, 1'b1, 1'b1);
    clear_frame();
    set_bin(3333, -12345, 6789);
    set_bin(42, 19134, 0);
    drive_frame(0, NP - 1, 1'b1, 1'b1);
    gaps = 1'b0;
    wait_drain(40);
    check_held("gaps_result", 42, 19134);
  endtask

  task automatic test_reset_midframe();
    int v0;
    clear_frame();
    set_bin(600, 7000, 0);
    drive_frame(0, 999, 1'b1, 1'b0);
    v0 = valid_cnt;
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("midframe_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    drive_frame(1000, NP - 1, 1'b0, 1'b0);
    idle(10);
    checks++;
    if (valid_cnt != v0 || o_peak_bin !== '0 || o_peak_mag !== '0) begin
      errors++;
      $display("FAIL reset_no_strobe: got valids=%0d bin=%0d mag=%0d, required 0 0 0",
               valid_cnt - v0, o_peak_bin, o_peak_mag);
    end
    drive_frame(0, NP - 1, 1'b1, 1'b1);
    wait_drain(20);
    check_held("after_reset_frame", 600, 7000);
  endtask

  task automatic test_dc_skip();
    clear_frame();
    set_bin(0, 100000, 0);
    set_bin(5, 10, 0);
    drive_frame(0, NP - 1, 1'b1, 1'b1);
    wait_drain(20);
`ifdef FFT_PEAK_DC_SKIP_EN
    check_held("dc_skip", 5, 10);
`else
    check_held("dc_search", 0, 100000);
`endif
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_ties();
    test_max_negative();
    test_resync();
    test_back_to_back();
    test_enable_gaps();
    test_reset_midframe();
    test_dc_skip();
    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
